// File: rtl/rv32i_trace_pkg.sv
// Shared types and defaults for the rv32i retirement-trace capture block.
package rv32i_trace_pkg;

    localparam int unsigned DROP_CNT_W          = 16;
    localparam int unsigned DEFAULT_DEPTH       = 16;
    localparam int unsigned DEFAULT_STALL_LIMIT = 8;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] wb;
    } trace_entry_t;

endpackage

// File: rtl/rv32i_wb_trace_capture_fifo.sv
// First-word-fall-through FIFO of trace entries; head reads zero when empty.
module trace_fifo
    import rv32i_trace_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     RN,
    input  logic                     clr,
    input  logic                     push,
    input  trace_entry_t             din,
    input  logic                     pop,
    output trace_entry_t             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;
    trace_entry_t mem [DEPTH];

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is accepted only when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/rv32i_wb_trace_capture.sv
// Logs {NPC, WB_OUT} on every NPC change into a FWFT FIFO, with drop
// accounting and a stall detector for a static NPC.
module rv32i_wb_trace_capture
    import rv32i_trace_pkg::*;
#(
    parameter int unsigned DEPTH       = DEFAULT_DEPTH,
    parameter int unsigned STALL_LIMIT = DEFAULT_STALL_LIMIT
) (
    input  logic                    clk,
    input  logic                    RN,
    input  logic [31:0]             NPC,
    input  logic [31:0]             WB_OUT,
    input  logic                    en,
    input  logic                    clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_npc,
    output logic [31:0]             out_wb,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic [DROP_CNT_W-1:0]   drop_cnt,
    output logic                    stalled
);

    localparam int unsigned SW = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

    logic [31:0]   prev_npc;
    logic          primed;
    logic [SW-1:0] stall_cnt;
    logic [SW-1:0] stall_cnt_nxt;
    logic          npc_changed;
    logic          pop;
    logic          drop;
    logic          fifo_full;
    logic          fifo_empty;
    trace_entry_t  din;
    trace_entry_t  head;

    assign npc_changed = en && primed && (NPC != prev_npc);
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    assign drop        = npc_changed && fifo_full && !pop;

    assign din.npc = NPC;
    assign din.wb  = WB_OUT;
    assign out_npc = head.npc;
    assign out_wb  = head.wb;

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .RN    (RN),
        .clr   (clr),
        .push  (npc_changed),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        stall_cnt_nxt = stall_cnt;
        if (en && primed) begin
            if (NPC != prev_npc)
                stall_cnt_nxt = '0;
            else if (stall_cnt != STALL_MAX)
                stall_cnt_nxt = stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            prev_npc  <= '0;
            primed    <= 1'b0;
            stall_cnt <= '0;
            stalled   <= 1'b0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else if (clr) begin
            prev_npc  <= '0;
            primed    <= 1'b0;
            stall_cnt <= '0;
            stalled   <= 1'b0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            // The first enabled edge only establishes the baseline PC.
            if (en) begin
                prev_npc <= NPC;
                primed   <= 1'b1;
            end
            stall_cnt <= stall_cnt_nxt;
            stalled   <= (stall_cnt_nxt == STALL_MAX);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_wb_trace_capture.sv
// Directed plus randomized bench for rv32i_wb_trace_capture against a queue-based model.
module tb_rv32i_wb_trace_capture;

    localparam int DEPTH = 16;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        RN = 1'b1;
    logic [31:0] NPC = '0;
    logic [31:0] WB_OUT = '0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_npc;
    logic [31:0] out_wb;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        stalled;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [31:0] q_npc[$];
    logic [31:0] q_wb[$];
    logic [31:0] m_prev;
    bit          m_primed;
    int          m_stall;
    bit          m_overflow;
    int          m_drop;

    rv32i_wb_trace_capture #(
        .DEPTH       (DEPTH),
        .STALL_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .RN        (RN),
        .NPC       (NPC),
        .WB_OUT    (WB_OUT),
        .en        (en),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_npc   (out_npc),
        .out_wb    (out_wb),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .stalled   (stalled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        q_npc.delete();
        q_wb.delete();
        m_prev     = '0;
        m_primed   = 0;
        m_stall    = 0;
        m_overflow = 0;
        m_drop     = 0;
    endtask

    // Applies the capture rules to the inputs present just before an edge.
    task automatic mdl_step();
        bit do_pop, do_push;
        if (RN || clr) begin
            mdl_reset();
            return;
        end
        do_pop  = (q_npc.size() != 0) && out_ready;
        do_push = en && m_primed && (NPC != m_prev);
        if (do_pop) begin
            void'(q_npc.pop_front());
            void'(q_wb.pop_front());
        end
        if (do_push) begin
            if (q_npc.size() < DEPTH) begin
                q_npc.push_back(NPC);
                q_wb.push_back(WB_OUT);
            end else begin
                m_overflow = 1;
                if (m_drop < 65535) m_drop++;
            end
        end
        if (en && m_primed) begin
            if (NPC != m_prev) m_stall = 0;
            else if (m_stall < LIMIT) m_stall++;
        end
        if (en) begin
            m_prev   = NPC;
            m_primed = 1;
        end
    endtask

    task automatic compare_all();
        bit nonempty;
        nonempty = q_npc.size() != 0;
        chk("out_valid", 32'(out_valid), 32'(nonempty));
        chk("count", 32'(count), 32'(q_npc.size()));
        chk("out_npc", out_npc, nonempty ? q_npc[0] : 32'h0);
        chk("out_wb", out_wb, nonempty ? q_wb[0] : 32'h0);
        chk("overflow", 32'(overflow), 32'(m_overflow));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("stalled", 32'(stalled), 32'(m_stall == LIMIT));
    endtask

    task automatic tick();
        mdl_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        // Reset defaults
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        RN = 1'b0;
        en = 1'b1;
        NPC = 32'h0;
        tick();
        chk("baseline_count", 32'(count), 32'h0);

        // Ordered capture
        NPC = 32'h4; WB_OUT = 32'h11; out_ready = 1'b0;
        tick();
        chk("first_head_npc", out_npc, 32'h4);
        chk("first_head_wb", out_wb, 32'h11);
        NPC = 32'h8; WB_OUT = 32'h22; out_ready = 1'b1;
        tick();
        chk("second_head_npc", out_npc, 32'h8);
        chk("second_head_wb", out_wb, 32'h22);
        tick();
        chk("drained_count", 32'(count), 32'h0);

        // Overflow: 18 changes into a 16-deep FIFO with no consumer
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            NPC = NPC + 32'h4;
            WB_OUT = $urandom;
            tick();
        end
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_drops", 32'(drop_cnt), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) tick();

        // Full FIFO with push and pop on the same edge
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            NPC = NPC + 32'h4;
            WB_OUT = $urandom;
            tick();
        end
        out_ready = 1'b1;
        NPC = NPC + 32'h4;
        WB_OUT = $urandom;
        tick();
        chk("full_pp_count", 32'(count), 32'd16);
        chk("full_pp_drops", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 16; i++) tick();

        // Stall detection
        NPC = 32'h20; WB_OUT = $urandom;
        tick();
        for (int i = 0; i < LIMIT; i++) tick();
        chk("stall_set", 32'(stalled), 32'h1);
        NPC = 32'h24; WB_OUT = 32'hCAFE_0024;
        out_ready = 1'b0;
        tick();
        chk("stall_clear", 32'(stalled), 32'h0);
        chk("stall_push_npc", out_npc, 32'h24);
        chk("stall_push_wb", out_wb, 32'hCAFE_0024);

        // Randomized traffic including clears
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            clr       = ($urandom_range(0, 59) == 0);
            WB_OUT    = $urandom;
            case ($urandom_range(0, 3))
                0:       NPC = $urandom;
                1:       NPC = NPC + 32'h4;
                default: NPC = NPC;
            endcase
            tick();
        end
        clr = 1'b0;
        en  = 1'b1;

        // Mid-operation asynchronous reset
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            NPC = NPC + 32'h4;
            WB_OUT = $urandom;
            tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            NPC = NPC + 32'h4;
            tick();
        end
        chk("pre_reset_overflow", 32'(overflow), 32'h1);
        RN = 1'b1;
        #1;
        mdl_reset();
        chk("async_count", 32'(count), 32'h0);
        chk("async_overflow", 32'(overflow), 32'h0);
        chk("async_valid", 32'(out_valid), 32'h0);
        #1;
        RN = 1'b0;

        // en gating after priming
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            NPC = NPC + 32'h4;
            WB_OUT = $urandom;
            tick();
        end
        chk("gated_count", 32'(count), 32'h0);
        chk("gated_stalled", 32'(stalled), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
